seg7_debug_display: RTL and testbench
=====================================

// Module: seg7_debug_display
// PURPOSE
//   Consumer end of the 32-bit debug readout: takes dbg_data (selected register/PC word)
//   and shows it as 8 hex digits on the board's time-multiplexed common-anode 7-segment
//   display. Snapshots dbg_data once per scan frame (no tearing), scans one digit per slot,
//   blanks anodes at slot start (anti-ghosting), optional leading-zero suppression.
// PARAMETERS
//   REFRESH_DIV  100000  clock cycles per digit slot (>= BLANK_CYC+1)
//   BLANK_CYC    4       cycles at start of each slot with all anodes off (>= 1)
//   NUM_DIGITS   8       digits scanned; digit d shows dbg_data[4d+3:4d]
// PORTS
//   clk          in   1   system clock
//   rst          in   1   synchronous reset, active-high
//   dbg_data     in   32  word to display (sampled only at frame start)
//   lz_en        in   1   1 = suppress leading zero digits (digit 0 never suppressed)
//   dp_mask      in   8   bit d = 1 lights decimal point of digit d (sampled live)
//   an           out  8   digit anodes, active-low, at most one low at a time
//   seg          out  7   segments {g,f,e,d,c,b,a}, active-low
//   dp           out  1   decimal point, active-low
//   frame_tick   out  1   1-cycle pulse: shadow reloaded this cycle
// BEHAVIOUR
//   State: div_cnt (0..REFRESH_DIV-1), idx (0..NUM_DIGITS-1), shadow[31:0].
//   Reset (rst=1 at edge): div_cnt=0, idx=0, shadow=0, an=8'hFF, seg=7'h7F, dp=1,
//     frame_tick=0. rst overrides everything, incl. mid-slot / mid-frame.
//   div_cnt increments each cycle; at REFRESH_DIV-1 wraps to 0 and idx advances,
//     idx NUM_DIGITS-1 wraps to 0.
//   Frame start: any edge where div_cnt==0 && idx==0 -> shadow<=dbg_data, frame_tick<=1;
//     frame_tick=0 otherwise. First load is the first edge after rst drops.
//   dbg_data changes between loads never reach the display.
//   Outputs registered, 1-cycle latency from state (div_cnt, idx, shadow):
//     blank = (div_cnt < BLANK_CYC) | lz_hide(idx)
//     an <= blank ? 8'hFF : ~(8'b1 << idx);  seg <= hex(shadow nibble idx);
//     dp <= blank ? 1 : ~dp_mask[idx].
//   lz_hide(idx) = lz_en && idx!=0 && shadow[31:4*idx]==0 (all nibbles idx..7 zero).
//   Since BLANK_CYC>=1, the stale-shadow cycle at frame start is always blanked.
//   hex(): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//     7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001
//     E=0000110 F=0001110 (bits g..a).
//   Lit time per digit = REFRESH_DIV-BLANK_CYC cycles; frame = NUM_DIGITS*REFRESH_DIV.
// TESTING (REFRESH_DIV=4, BLANK_CYC=1 unless noted)
//   1 Reset: hold rst 3 cycles -> an=FF, seg=7F, dp=1, frame_tick=0; release -> frame_tick
//     high exactly 1 cycle, then every 32 cycles.
//   2 dbg_data=32'h12345678, lz_en=0 -> per slot 1 blank cycle then 3 lit: an=FE seg=0000000,
//     an=FD seg=1111000, ... an=7F seg=1111001; never two anodes low.
//   3 Load 32'hDEADBEEF, change to 32'h0 mid-frame -> rest of frame still DEADBEEF digits;
//     next frame shows 0 on all digits.
//   4 dbg_data=32'h000000A5, lz_en=1 -> only an=FE (5=0010010) and an=FD (A=0001000) ever
//     go low; dbg_data=0 -> only digit 0 lit showing 1000000.
//   5 dp_mask=8'h01, dbg_data=32'h0 -> dp=0 only while an=FE; dp=1 during blank cycles.
//   6 Assert rst during idx=5 lit cycle -> next cycle an=FF; scan restarts at idx 0 with
//     fresh frame_tick after release.

Source files
------------

// File: rtl/seg7_debug_display.sv
// Shows a 32-bit debug word as hex digits on a multiplexed common-anode 7-segment display.
// The word is snapshotted once per scan frame, and each digit slot opens with a few anode-off cycles.
module seg7_debug_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 4,
  parameter int NUM_DIGITS  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dbg_data,
  input  logic        lz_en,
  input  logic [7:0]  dp_mask,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_tick
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      shadow;

  logic [3:0] nibble;
  logic       lz_hide;
  logic       blank;
  logic       frame_start;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    nibble      = 4'(shadow >> {idx, 2'b00});
    lz_hide     = lz_en && (idx != '0) && ((shadow >> {idx, 2'b00}) == 32'h0);
    blank       = (div_cnt < BLANK_END) || lz_hide;
    frame_start = (div_cnt == '0) && (idx == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= '0;
      idx        <= '0;
      shadow     <= 32'h0;
      an         <= 8'hFF;
      seg        <= 7'h7F;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (frame_start) shadow <= dbg_data;
      frame_tick <= frame_start;

      // Outputs follow the pre-edge state, so the frame-start cycle still shows the old
      // shadow; it is always inside the blanking window, so the old value is never visible.
      an  <= blank ? 8'hFF : ~(8'b1 << idx);
      seg <= hex7(nibble);
      dp  <= blank ? 1'b1 : ~dp_mask[idx];
    end
  end

endmodule

// File: tb/tb_seg7_debug_display.sv
// Randomized bench for seg7_debug_display; expected outputs come from a cycle-count model
// that derives the slot, digit and significant-digit count arithmetically.
module tb_seg7_debug_display;

  localparam int REFRESH_DIV = 4;
  localparam int BLANK_CYC   = 1;
  localparam int NUM_DIGITS  = 8;
  localparam int FRAME       = REFRESH_DIV * NUM_DIGITS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dbg_data = 32'h0;
  logic        lz_en = 1'b0;
  logic [7:0]  dp_mask = 8'h00;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  int n_checks = 0;
  int n_errors = 0;

  int          m_n;
  logic [31:0] m_shadow;
  logic [6:0]  hex_tab [16];

  seg7_debug_display #(
    .REFRESH_DIV(REFRESH_DIV),
    .BLANK_CYC  (BLANK_CYC),
    .NUM_DIGITS (NUM_DIGITS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .dbg_data  (dbg_data),
    .lz_en     (lz_en),
    .dp_mask   (dp_mask),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t, n=%0d)", tag, obs, exp, $time, m_n);
    end
  endtask

  // One clock edge: predict outputs from the inputs now applied, then compare after the edge.
  task automatic cycle();
    logic [7:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp, e_ft, hide;
    int         slot_pos, digit, sig;
    if (rst) begin
      e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_ft = 1'b0;
    end else begin
      slot_pos = m_n % REFRESH_DIV;
      digit    = (m_n / REFRESH_DIV) % NUM_DIGITS;
      sig = 1;
      for (int d = 0; d < NUM_DIGITS; d++)
        if (m_shadow[4*d +: 4] != 4'h0) sig = d + 1;
      hide  = lz_en && (digit >= sig);
      e_an  = (slot_pos < BLANK_CYC || hide) ? 8'hFF : ~(8'h01 << digit);
      e_dp  = (slot_pos < BLANK_CYC || hide) ? 1'b1 : ~dp_mask[digit];
      e_seg = hex_tab[m_shadow[4*digit +: 4]];
      e_ft  = (m_n % FRAME) == 0;
    end
    @(posedge clk);
    #1;
    check("an", an, e_an);
    check("seg", seg, e_seg);
    check("dp", dp, e_dp);
    check("frame_tick", frame_tick, e_ft);
    check("an_single_low", ($countones(~an) <= 1), 1);
    if (rst) begin
      m_n = 0;
      m_shadow = 32'h0;
    end else begin
      if (m_n % FRAME == 0) m_shadow = dbg_data;
      m_n++;
    end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) cycle();
  endtask

  initial begin
    hex_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    m_n = 0;
    m_shadow = 32'h0;

    // reset held, then plain scan of a known word
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    dbg_data = 32'h12345678;
    dp_mask = 8'h5A;
    run(2 * FRAME);

    // snapshot must hold for the whole frame
    dbg_data = 32'hDEADBEEF;
    run(FRAME / 2);
    dbg_data = 32'h0;
    run(FRAME + FRAME / 2);

    // leading-zero suppression
    lz_en = 1'b1;
    dp_mask = 8'hFF;
    dbg_data = 32'h000000A5;
    run(2 * FRAME);
    dbg_data = 32'h0;
    run(2 * FRAME);

    // decimal point on digit 0 only
    lz_en = 1'b0;
    dp_mask = 8'h01;
    run(2 * FRAME);

    // reset in the middle of digit 5's lit window
    dbg_data = 32'hCAFE0123;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (((m_n / REFRESH_DIV) % NUM_DIGITS) == 5 && (m_n % REFRESH_DIV) == 2) break;
      cycle();
    end
    check("reached_idx5", ((m_n / REFRESH_DIV) % NUM_DIGITS), 5);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    run(2 * FRAME);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)
        dbg_data = $urandom >> (4 * $urandom_range(0, 8));
      if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
      if ($urandom_range(0, 3) == 0) dp_mask = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cycle();
    end
    rst = 1'b0;
    run(FRAME);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
